// File: rtl/fifo_drain_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fifo_drain_tx
// Description : Drains words from a FIFO read port and sends each one as a
//               serial frame: start bit (0), DATA_W data bits LSB first,
//               optional even-parity bit, stop bit (1). Each bit is held for
//               CLKS_PER_BIT clock cycles. The line idles high.
// Ports       : clk         - system clock, rising edge
//               reset       - asynchronous active-high reset
//               tx_enable   - permission to start a new frame (seen in IDLE)
//               fifo_empty  - FIFO empty flag
//               fifo_rdata  - FIFO read data, valid the cycle after the pop
//               fifo_rd_en  - one-cycle pop pulse
//               tx_line     - serial output
//               busy        - high whenever a frame is in progress
//               word_count  - completed frames, wraps 255 -> 0
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_drain_tx #(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              fifo_rd_en,
  output logic              tx_line,
  output logic              busy,
  output logic [7:0]        word_count
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] c_last_bit = BIT_W'(DATA_W - 1);
  localparam logic [7:0]       c_div_last = 8'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [7:0]        r_div;
  logic [BIT_W-1:0]  r_bit_idx;
  logic [DATA_W-1:0] r_shift;
  logic              r_parity;
  logic [7:0]        r_word_count;
  logic              w_bit_done;
  logic              w_last_bit;
  logic              w_serial_state;

  // End of the current serial bit period.
  assign w_bit_done     = (r_div == c_div_last);
  assign w_last_bit     = (r_bit_idx == c_last_bit);
  assign w_serial_state = (r_state == S_START) || (r_state == S_DATA) ||
                          (r_state == S_PARITY) || (r_state == S_STOP);
  assign word_count     = r_word_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and Moore-decoded outputs; outputs depend only on state and
  // registered datapath, never directly on inputs.
  always_comb begin
    w_next_state = r_state;
    fifo_rd_en   = 1'b0;
    busy         = 1'b1;
    tx_line      = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (tx_enable && !fifo_empty) begin
          w_next_state = S_READ;
        end
      end
      S_READ: begin
        fifo_rd_en   = 1'b1;
        w_next_state = S_LOAD;
      end
      S_LOAD: begin
        w_next_state = S_START;
      end
      S_START: begin
        tx_line = 1'b0;
        if (w_bit_done) begin
          w_next_state = S_DATA;
        end
      end
      S_DATA: begin
        tx_line = r_shift[0];
        if (w_bit_done && w_last_bit) begin
          w_next_state = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        tx_line = r_parity;
        if (w_bit_done) begin
          w_next_state = S_STOP;
        end
      end
      S_STOP: begin
        if (w_bit_done) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div        <= 8'd0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_parity     <= 1'b0;
      r_word_count <= 8'd0;
    end else begin
      // Divider runs only while bits are on the line and restarts each bit.
      if (w_serial_state && !w_bit_done) begin
        r_div <= r_div + 8'd1;
      end else begin
        r_div <= 8'd0;
      end

      case (r_state)
        S_LOAD: begin
          // FIFO read data is valid now, one cycle after the pop.
          r_shift   <= fifo_rdata;
          r_parity  <= ^fifo_rdata;
          r_bit_idx <= '0;
        end
        S_DATA: begin
          if (w_bit_done) begin
            r_shift   <= r_shift >> 1;
            r_bit_idx <= r_bit_idx + 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_done) begin
            r_word_count <= r_word_count + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire
